// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared types for the sync_fifo_v2 family. Imported by the FIFO top and by
// anything that instantiates it, so the read-mode parameter is typed.
//   fifo_mode_e : FIFO_MODE_STD  - registered read, rdvalid pulses after rden
//                 FIFO_MODE_FWFT - head word always presented, rden pops it
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// FIFO_DEPTH x FIFO_WIDTH storage array with one synchronous write port and
// one asynchronous read port. Holds no control state; the FIFO top owns the
// pointers and decides when a write really happens.
// Ports:
//   clk    in  clock
//   we     in  write enable, sampled on the rising edge
//   waddr  in  write address (0..FIFO_DEPTH-1)
//   wdata  in  write data
//   raddr  in  read address (0..FIFO_DEPTH-1)
//   rdata  out data at raddr, combinational
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_WIDTH = 8,
  localparam int unsigned ADDR_W    = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [FIFO_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [FIFO_WIDTH-1:0] rdata
);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // NOTE: the array has no reset branch on purpose; a reset on storage turns
  // it into thousands of resettable flops instead of a RAM. Stale contents are
  // harmless because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_v2.sv
// -----------------------------------------------------------------------------
// sync_fifo_v2
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// selectable standard or first-word-fall-through read mode, and optional
// sticky overflow/underflow flags.
// Optional feature macro: SYNC_FIFO_ERR_EN (adds err_clr/overflow/underflow).
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rstn         in   synchronous active-low reset
//   wren/wrdata  in   write request and data
//   rden         in   STD: read strobe; FWFT: pop the presented head word
//   rddata       out  read data
//   rdvalid      out  rddata holds a valid word
//   full, almost_full, empty, almost_empty  out  flags decoded from count
//   count        out  current occupancy
//   err_clr      in   clear sticky error flags        (SYNC_FIFO_ERR_EN)
//   overflow     out  sticky: write dropped while full (SYNC_FIFO_ERR_EN)
//   underflow    out  sticky: read while empty         (SYNC_FIFO_ERR_EN)
// -----------------------------------------------------------------------------
module sync_fifo_v2
  import sync_fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned FIFO_WIDTH    = 8,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  parameter fifo_mode_e  MODE          = FIFO_MODE_STD,
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wren,
  input  logic [FIFO_WIDTH-1:0] wrdata,
  input  logic                  rden,
  output logic [FIFO_WIDTH-1:0] rddata,
  output logic                  rdvalid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int unsigned   PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIFO_WIDTH-1:0] rddata_q, rddata_d;
  logic                  rdvalid_q, rdvalid_d;

  logic                  wr_acc, rd_acc, mem_we;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  // Flags decode only the count register, so no request input reaches them
  // combinationally.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;

  // A full FIFO still takes a write when the same edge frees a slot.
  assign rd_acc = rden && !empty;
  assign wr_acc = wren && (!full || rd_acc);
  assign mem_we = wr_acc && rstn;

  sync_fifo_mem #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wrdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // NOTE: every signal gets its hold/default value before any condition, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rddata_d  = rddata_q;
    rdvalid_d = 1'b0;

    // Explicit wrap compare: FIFO_DEPTH need not be a power of two.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

    if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

    // STD mode captures the head word at the accepting edge; FWFT bypasses
    // these registers entirely.
    if (MODE == FIFO_MODE_STD && rd_acc) begin
      rddata_d  = mem_rdata;
      rdvalid_d = 1'b1;
    end
  end

  // NOTE: rstn is sampled only at the clock edge (synchronous reset), and all
  // state uses non-blocking assignments so every flop updates from pre-edge
  // values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rddata_q  <= rddata_d;
      rdvalid_q <= rdvalid_d;
    end
  end

  // FWFT drives zero while empty so the output never exposes unreset storage.
  assign rddata  = (MODE == FIFO_MODE_FWFT) ? (empty ? '0 : mem_rdata) : rddata_q;
  assign rdvalid = (MODE == FIFO_MODE_FWFT) ? !empty : rdvalid_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new event in the clearing cycle wins over err_clr.
  always_comb begin
    overflow_d  = (wren && full && !rd_acc) || (overflow_q && !err_clr);
    underflow_d = (rden && empty) || (underflow_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : sync_fifo_v2
